rr_arb_n: RTL and testbench

//  N-input round-robin AXI-Stream arbiter with an optional TLAST packet lock and a selectable output pipeline stage.
//  It generalises the fixed 4-input arbiter to any input count, and adds a source-ID sideband (o_TID) and a fixed-priority mode.
//  It sits in front of shared stream sinks (DMA, network egress) and merges N producers onto one channel.

---
 rtl/rr_arb_n_if.sv | 33 +++
 rtl/rr_arb_n.sv | 148 ++++++++++++++
 tb/tb_rr_arb_n.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arb_n_if.sv
// Stream bundle for the N-input round-robin arbiter: N producer lanes in, one merged lane out.
// slave  : the arbiter's view (consumes s_*, produces o_*).
// master : the environment's view (drives s_* and o_TREADY).
interface rr_arb_n_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_INPUTS   = 4
);
  localparam int ID_WIDTH = $clog2(N_INPUTS);

  logic [N_INPUTS*DATA_WIDTH-1:0] s_TDATA;
  logic [N_INPUTS-1:0]            s_TVALID;
  logic [N_INPUTS-1:0]            s_TLAST;
  logic [N_INPUTS-1:0]            s_TREADY;
  logic [DATA_WIDTH-1:0]          o_TDATA;
  logic [ID_WIDTH-1:0]            o_TID;
  logic                           o_TLAST;
  logic                           o_TVALID;
  logic                           o_TREADY;

  modport slave (
    input  s_TDATA, s_TVALID, s_TLAST,
    output s_TREADY,
    output o_TDATA, o_TID, o_TLAST, o_TVALID,
    input  o_TREADY
  );

  modport master (
    output s_TDATA, s_TVALID, s_TLAST,
    input  s_TREADY,
    input  o_TDATA, o_TID, o_TLAST, o_TVALID,
    output o_TREADY
  );
endinterface

// File: rtl/rr_arb_n.sv
// N-input AXI-Stream arbiter: round-robin or fixed priority, optional TLAST packet
// lock, optional 2-entry skid buffer on the output so o_TREADY never reaches s_TREADY.
module rr_arb_n #(
  parameter int DATA_WIDTH = 8,
  parameter int N_INPUTS   = 4,
  parameter int PIPE_STAGE = 1,
  parameter int TLAST_ARB  = 1,
  parameter int ARB_MODE   = 0
) (
  input logic        clk,
  input logic        rst,
  rr_arb_n_if.slave  bus
);
  localparam int          ID_WIDTH = $clog2(N_INPUTS);
  localparam int unsigned NU       = N_INPUTS;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t                r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]   r_ptr, w_ptr_nxt;
  logic [ID_WIDTH-1:0]   r_lock, w_lock_nxt;
  logic [ID_WIDTH-1:0]   w_grant;
  logic                  w_gnt_valid;
  logic                  w_can_accept;
  logic                  w_fire;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;

  // Grant selection: locked lane, else lowest index (fixed) or first valid after ptr (round-robin)
  always_comb begin
    w_grant     = '0;
    w_gnt_valid = 1'b0;
    if (r_state == ST_LOCKED) begin
      w_grant     = r_lock;
      w_gnt_valid = bus.s_TVALID[r_lock];
    end else if (ARB_MODE == 1) begin
      // Descending scan: the last hit written is the lowest valid index.
      for (int unsigned k = NU; k > 0; k--) begin
        if (bus.s_TVALID[ID_WIDTH'(k - 1)]) begin
          w_grant     = ID_WIDTH'(k - 1);
          w_gnt_valid = 1'b1;
        end
      end
    end else begin
      // Offsets scanned from N down to 1 so offset 1 (ptr+1) wins; offset N is ptr itself.
      for (int unsigned k = NU; k > 0; k--) begin
        if (bus.s_TVALID[ID_WIDTH'((32'(r_ptr) + k) % NU)]) begin
          w_grant     = ID_WIDTH'((32'(r_ptr) + k) % NU);
          w_gnt_valid = 1'b1;
        end
      end
    end
  end

  assign w_fire = !rst && w_gnt_valid && w_can_accept;
  assign w_data = bus.s_TDATA[w_grant*DATA_WIDTH +: DATA_WIDTH];
  assign w_last = bus.s_TLAST[w_grant];

  // Per-input ready: one-hot on the granted lane when the beat can move, zero otherwise
  always_comb begin
    bus.s_TREADY = '0;
    if (w_fire) bus.s_TREADY[w_grant] = 1'b1;
  end

  // Next lock/pointer state from the accepted beat
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_lock_nxt  = r_lock;
    if (w_fire) begin
      if (TLAST_ARB == 0 || w_last) begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = w_grant;
      end else begin
        w_state_nxt = ST_LOCKED;
        w_lock_nxt  = w_grant;
      end
    end
  end

  // Arbitration state register; reset leaves ptr on the last lane so lane 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= ID_WIDTH'(N_INPUTS - 1);
      r_lock  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  generate
    if (PIPE_STAGE == 0) begin : g_comb
      assign w_can_accept = bus.o_TREADY;
      assign bus.o_TVALID = !rst && w_gnt_valid;
      assign bus.o_TDATA  = rst ? '0 : w_data;
      assign bus.o_TLAST  = !rst && w_last;
      assign bus.o_TID    = rst ? '0 : w_grant;
    end else begin : g_skid
      logic                  r_ov, r_olast, r_sv, r_slast;
      logic [DATA_WIDTH-1:0] r_odata, r_sdata;
      logic [ID_WIDTH-1:0]   r_oid, r_sid;

      // Ready depends only on the skid flop, breaking the o_TREADY -> s_TREADY path
      assign w_can_accept = !r_sv;
      assign bus.o_TVALID = r_ov;
      assign bus.o_TDATA  = r_odata;
      assign bus.o_TLAST  = r_olast;
      assign bus.o_TID    = r_oid;

      // Output register refills from skid first, else from the arbiter; stalled beats park in skid
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ov    <= 1'b0;
          r_odata <= '0;
          r_olast <= 1'b0;
          r_oid   <= '0;
          r_sv    <= 1'b0;
          r_sdata <= '0;
          r_slast <= 1'b0;
          r_sid   <= '0;
        end else if (!r_ov || bus.o_TREADY) begin
          if (r_sv) begin
            r_ov    <= 1'b1;
            r_odata <= r_sdata;
            r_olast <= r_slast;
            r_oid   <= r_sid;
            r_sv    <= 1'b0;
          end else begin
            r_ov <= w_fire;
            if (w_fire) begin
              r_odata <= w_data;
              r_olast <= w_last;
              r_oid   <= w_grant;
            end
          end
        end else if (w_fire) begin
          r_sv    <= 1'b1;
          r_sdata <= w_data;
          r_slast <= w_last;
          r_sid   <= w_grant;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_rr_arb_n.sv
// Directed checks of the 4-input pipelined arbiter and an 8-input fixed-priority
// combinational arbiter, plus a randomized per-lane sequence-counter run.
module tb_rr_arb_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rr_arb_n_if #(.DATA_WIDTH(8), .N_INPUTS(4)) ifa ();
  rr_arb_n_if #(.DATA_WIDTH(8), .N_INPUTS(8)) ifb ();

  rr_arb_n #(.DATA_WIDTH(8), .N_INPUTS(4), .PIPE_STAGE(1), .TLAST_ARB(1), .ARB_MODE(0))
    u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  rr_arb_n #(.DATA_WIDTH(8), .N_INPUTS(8), .PIPE_STAGE(0), .TLAST_ARB(1), .ARB_MODE(1))
    u_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic [5:0] sent [4];
  logic [5:0] expc [4];
  logic       tl_hist [4][64];
  logic       last_tl;
  logic [1:0] last_id;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic [1:0] prev_tid;
  int         n_in, n_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane_a(input int i, input logic [7:0] d);
    ifa.s_TDATA[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifa.s_TVALID = '0;
    ifb.s_TVALID = '0;
    tick();
    rst = 1'b0;
  endtask

  // One randomized cycle: drive random stimulus, score the output beat, record input accepts.
  task automatic rnd_cycle(input bit drain);
    logic [1:0] id;
    if (drain) begin
      ifa.s_TVALID = '0;
      ifa.o_TREADY = 1'b1;
    end else begin
      ifa.s_TVALID = 4'($urandom);
      ifa.s_TLAST  = 4'($urandom);
      ifa.o_TREADY = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) lane_a(i, {2'(i), sent[i]});
    #1;
    chk("rnd_onehot", 32'($onehot0(ifa.s_TREADY)), 32'd1);
    if (prev_stall) begin
      chk("rnd_hold_valid", 32'(ifa.o_TVALID), 32'd1);
      chk("rnd_hold_data", 32'(ifa.o_TDATA), 32'(prev_data));
      chk("rnd_hold_tid", 32'(ifa.o_TID), 32'(prev_tid));
    end
    if (ifa.o_TVALID && ifa.o_TREADY) begin
      id = ifa.o_TDATA[7:6];
      chk("rnd_tid", 32'(ifa.o_TID), 32'(id));
      chk("rnd_seq", 32'(ifa.o_TDATA[5:0]), 32'(expc[id]));
      chk("rnd_last", 32'(ifa.o_TLAST), 32'(tl_hist[id][expc[id]]));
      if (!last_tl) chk("rnd_lock", 32'(id), 32'(last_id));
      expc[id]++;
      last_tl = ifa.o_TLAST;
      last_id = id;
      n_out++;
    end
    prev_stall = ifa.o_TVALID && !ifa.o_TREADY;
    prev_data  = ifa.o_TDATA;
    prev_tid   = ifa.o_TID;
    for (int i = 0; i < 4; i++) begin
      if (ifa.s_TVALID[i] && ifa.s_TREADY[i]) begin
        tl_hist[i][sent[i]] = ifa.s_TLAST[i];
        sent[i]++;
        n_in++;
      end
    end
    tick();
  endtask

  initial begin
    ifa.s_TDATA = '0; ifa.s_TVALID = '0; ifa.s_TLAST = '0; ifa.o_TREADY = 1'b1;
    ifb.s_TDATA = '0; ifb.s_TVALID = '0; ifb.s_TLAST = '0; ifb.o_TREADY = 1'b1;
    tick();
    tick();

    // Reset state, with all inputs requesting
    ifa.s_TVALID = '1; ifa.s_TLAST = '1;
    for (int i = 0; i < 4; i++) lane_a(i, 8'h10 + 8'(i));
    #1;
    chk("rst_tvalid", 32'(ifa.o_TVALID), 32'd0);
    chk("rst_tready", 32'(ifa.s_TREADY), 32'd0);
    chk("rst_tid",    32'(ifa.o_TID),    32'd0);
    chk("rst_tdata",  32'(ifa.o_TDATA),  32'd0);
    chk("rst_tlast",  32'(ifa.o_TLAST),  32'd0);

    // All valid, TLAST=1: rotation 0,1,2,3,... one beat per cycle after 1-cycle latency
    rst = 1'b0;
    #1;
    chk("rr_c0_tready", 32'(ifa.s_TREADY), 32'h1);
    chk("rr_c0_tvalid", 32'(ifa.o_TVALID), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      #1;
      chk("rr_tready", 32'(ifa.s_TREADY), 32'(1 << (k % 4)));
      chk("rr_tvalid", 32'(ifa.o_TVALID), 32'd1);
      chk("rr_tid",    32'(ifa.o_TID),    32'((k - 1) % 4));
      chk("rr_tdata",  32'(ifa.o_TDATA),  32'(8'h10 + 8'((k - 1) % 4)));
    end

    // 3-beat packet from lane 1 while lane 2 waits; no interleave
    do_reset();
    ifa.s_TVALID = 4'b0110; ifa.s_TLAST = 4'b0100; lane_a(1, 8'hA1); lane_a(2, 8'hB1);
    #1; chk("pkt_c0_tready", 32'(ifa.s_TREADY), 32'h2);
    tick(); lane_a(1, 8'hA2); #1;
    chk("pkt_c1_tready", 32'(ifa.s_TREADY), 32'h2);
    chk("pkt_c1_tid",    32'(ifa.o_TID),    32'd1);
    chk("pkt_c1_tdata",  32'(ifa.o_TDATA),  32'hA1);
    chk("pkt_c1_tlast",  32'(ifa.o_TLAST),  32'd0);
    tick(); lane_a(1, 8'hA3); ifa.s_TLAST = 4'b0110; #1;
    chk("pkt_c2_tready", 32'(ifa.s_TREADY), 32'h2);
    chk("pkt_c2_tdata",  32'(ifa.o_TDATA),  32'hA2);
    tick(); lane_a(1, 8'hA4); ifa.s_TLAST = 4'b0100; #1;
    chk("pkt_c3_tready", 32'(ifa.s_TREADY), 32'h4);
    chk("pkt_c3_tid",    32'(ifa.o_TID),    32'd1);
    chk("pkt_c3_tdata",  32'(ifa.o_TDATA),  32'hA3);
    chk("pkt_c3_tlast",  32'(ifa.o_TLAST),  32'd1);
    tick(); #1;
    chk("pkt_c4_tid",    32'(ifa.o_TID),    32'd2);
    chk("pkt_c4_tdata",  32'(ifa.o_TDATA),  32'hB1);
    chk("pkt_c4_tready", 32'(ifa.s_TREADY), 32'h2);

    // Locked lane 1 drops valid for 2 cycles while lane 0 requests
    do_reset();
    ifa.s_TVALID = 4'b0010; ifa.s_TLAST = 4'b0000; lane_a(1, 8'hC1); lane_a(0, 8'hE0);
    #1; chk("gap_c0_tready", 32'(ifa.s_TREADY), 32'h2);
    tick(); ifa.s_TVALID = 4'b0001; #1;
    chk("gap_c1_tready", 32'(ifa.s_TREADY), 32'h0);
    chk("gap_c1_tvalid", 32'(ifa.o_TVALID), 32'd1);
    chk("gap_c1_tdata",  32'(ifa.o_TDATA),  32'hC1);
    tick(); #1;
    chk("gap_c2_tready", 32'(ifa.s_TREADY), 32'h0);
    chk("gap_c2_tvalid", 32'(ifa.o_TVALID), 32'd0);
    tick(); ifa.s_TVALID = 4'b0011; ifa.s_TLAST = 4'b0010; lane_a(1, 8'hC2); #1;
    chk("gap_c3_tready", 32'(ifa.s_TREADY), 32'h2);
    chk("gap_c3_tvalid", 32'(ifa.o_TVALID), 32'd0);
    tick(); ifa.s_TVALID = 4'b0001; #1;
    chk("gap_c4_tid",    32'(ifa.o_TID),    32'd1);
    chk("gap_c4_tdata",  32'(ifa.o_TDATA),  32'hC2);
    chk("gap_c4_tlast",  32'(ifa.o_TLAST),  32'd1);
    chk("gap_c4_tready", 32'(ifa.s_TREADY), 32'h1);

    // Back-pressure 5 cycles on lane 3: exactly 2 beats absorbed, then D0,D1,D2,D3 in order
    do_reset();
    ifa.o_TREADY = 1'b0; ifa.s_TVALID = 4'b1000; ifa.s_TLAST = 4'b1000; lane_a(3, 8'hD0);
    #1;
    chk("bp_c0_tready", 32'(ifa.s_TREADY), 32'h8);
    chk("bp_c0_tvalid", 32'(ifa.o_TVALID), 32'd0);
    tick(); lane_a(3, 8'hD1); #1;
    chk("bp_c1_tready", 32'(ifa.s_TREADY), 32'h8);
    chk("bp_c1_tdata",  32'(ifa.o_TDATA),  32'hD0);
    chk("bp_c1_tid",    32'(ifa.o_TID),    32'd3);
    tick(); lane_a(3, 8'hD2);
    for (int k = 2; k <= 4; k++) begin
      #1;
      chk("bp_stall_tready", 32'(ifa.s_TREADY), 32'h0);
      chk("bp_stall_tvalid", 32'(ifa.o_TVALID), 32'd1);
      chk("bp_stall_tdata",  32'(ifa.o_TDATA),  32'hD0);
      tick();
    end
    ifa.o_TREADY = 1'b1; #1;
    chk("bp_c5_tready", 32'(ifa.s_TREADY), 32'h0);
    chk("bp_c5_tdata",  32'(ifa.o_TDATA),  32'hD0);
    tick(); #1;
    chk("bp_c6_tdata",  32'(ifa.o_TDATA),  32'hD1);
    chk("bp_c6_tready", 32'(ifa.s_TREADY), 32'h8);
    tick(); lane_a(3, 8'hD3); #1;
    chk("bp_c7_tdata",  32'(ifa.o_TDATA),  32'hD2);
    chk("bp_c7_tready", 32'(ifa.s_TREADY), 32'h8);
    tick(); ifa.s_TVALID = 4'b0000; #1;
    chk("bp_c8_tdata",  32'(ifa.o_TDATA),  32'hD3);
    chk("bp_c8_tready", 32'(ifa.s_TREADY), 32'h0);
    tick(); #1;
    chk("bp_c9_tvalid", 32'(ifa.o_TVALID), 32'd0);

    // Reset mid-packet from lane 2: skid dropped, lock discarded, lane 0 wins next
    do_reset();
    ifa.s_TVALID = 4'b0100; ifa.s_TLAST = 4'b0000; lane_a(2, 8'hF0);
    #1; chk("mrst_c0_tready", 32'(ifa.s_TREADY), 32'h4);
    tick(); rst = 1'b1; lane_a(2, 8'hF1); #1;
    chk("mrst_c1_tready", 32'(ifa.s_TREADY), 32'h0);
    tick(); rst = 1'b0; ifa.s_TVALID = 4'b1111; ifa.s_TLAST = 4'b1111;
    for (int i = 0; i < 4; i++) lane_a(i, 8'h20 + 8'(i));
    #1;
    chk("mrst_c2_tvalid", 32'(ifa.o_TVALID), 32'd0);
    chk("mrst_c2_tready", 32'(ifa.s_TREADY), 32'h1);
    tick(); #1;
    chk("mrst_c3_tid",    32'(ifa.o_TID),    32'd0);
    chk("mrst_c3_tdata",  32'(ifa.o_TDATA),  32'h20);
    chk("mrst_c3_tready", 32'(ifa.s_TREADY), 32'h2);

    // Fixed priority, 8 inputs, combinational path: lane 3 beats lane 6 until it goes idle
    ifb.s_TVALID = 8'b0100_1000; ifb.s_TLAST = '1;
    ifb.s_TDATA[3*8 +: 8] = 8'h33; ifb.s_TDATA[6*8 +: 8] = 8'h66;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fp_tid",    32'(ifb.o_TID),    32'd3);
      chk("fp_tdata",  32'(ifb.o_TDATA),  32'h33);
      chk("fp_tready", 32'(ifb.s_TREADY), 32'h08);
      tick();
    end
    ifb.s_TVALID = 8'b0100_0000; #1;
    chk("fp_idle3_tid",    32'(ifb.o_TID),    32'd6);
    chk("fp_idle3_tdata",  32'(ifb.o_TDATA),  32'h66);
    chk("fp_idle3_tready", 32'(ifb.s_TREADY), 32'h40);
    ifb.o_TREADY = 1'b0; #1;
    chk("fp_bp_tready", 32'(ifb.s_TREADY), 32'h00);
    chk("fp_bp_tvalid", 32'(ifb.o_TVALID), 32'd1);
    tick(); ifb.o_TREADY = 1'b1; ifb.s_TVALID = '0; #1;
    chk("fp_none_tvalid", 32'(ifb.o_TVALID), 32'd0);

    // Randomized per-lane sequence counters through the pipelined arbiter
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sent[i] = '0;
      expc[i] = '0;
    end
    last_tl = 1'b1; last_id = '0; prev_stall = 1'b0; prev_data = '0; prev_tid = '0;
    n_in = 0; n_out = 0;
    for (int c = 0; c < 400; c++) rnd_cycle(1'b0);
    for (int c = 0; c < 4; c++) rnd_cycle(1'b1);
    chk("rnd_count", 32'(n_out), 32'(n_in));
    #1;
    chk("rnd_empty", 32'(ifa.o_TVALID), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
